// File: rtl/freq_meas_pkg.sv
// Shared definitions for the frequency-measurement result path.
// Provides the data/counter widths, the capture FSM state type and the
// reset value of the running minimum.
package freq_meas_pkg;

    localparam int unsigned FREQ_W = 64;
    localparam int unsigned CNT_W  = 32;

    typedef logic [FREQ_W-1:0] freq_t;

    localparam freq_t MIN_RESET = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        UPDATE
    } state_t;

endpackage

// File: rtl/freq_result_capture_if.sv
// Result handshake between the capture block and the DMA/register side.
//   res_valid : holding register is full (driven by master)
//   res_ready : consumer accepts when res_valid & res_ready (driven by slave)
//   res_data  : latest accepted frequency in Hz (driven by master)
interface freq_result_capture_if;
    import freq_meas_pkg::*;

    logic  res_valid;
    logic  res_ready;
    freq_t res_data;

    modport master (output res_valid, output res_data, input res_ready);
    modport slave  (input res_valid, input res_data, output res_ready);

endinterface

// File: rtl/freq_stable_sampler.sv
// Settle timer and stability qualifier for the asynchronous counter result.
// Ports:
//   sys_clk_50m, sys_rst_n : clock, async active-low reset
//   state                  : capture FSM state owned by the top
//   freq_in                : counter result, asynchronous to sys_clk_50m
//   settle_done_c          : last SETTLE cycle
//   stable_c               : STABLE_SAMPLES equal samples seen this cycle
//   err_c                  : MAX_RETRY mismatches seen this cycle
//   value                  : last sample; holds the qualified value in UPDATE
module freq_stable_sampler
    import freq_meas_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned STABLE_SAMPLES = 3,
    parameter int unsigned MAX_RETRY      = 8
) (
    input  logic   sys_clk_50m,
    input  logic   sys_rst_n,
    input  state_t state,
    input  freq_t  freq_in,
    output logic   settle_done_c,
    output logic   stable_c,
    output logic   err_c,
    output freq_t  value
);

    localparam int unsigned TIMER_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned MATCH_W = 4;
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    freq_t              freq_s;
    freq_t              prev_q;
    logic [TIMER_W-1:0] timer_q;
    logic [MATCH_W-1:0] match_q;
    logic [RETRY_W-1:0] retry_q;
    logic               is_match_c;

    // Bus is only trusted once several consecutive captures agree, which
    // covers both metastable bits and inter-bit skew of the async result.
    assign is_match_c    = (freq_s == prev_q);
    assign settle_done_c = (state == SETTLE) && (timer_q == TIMER_W'(SETTLE_CYCLES - 1));
    assign stable_c      = (state == SAMPLE) && is_match_c
                           && (match_q == MATCH_W'(STABLE_SAMPLES - 2));
    assign err_c         = (state == SAMPLE) && !is_match_c
                           && (retry_q == RETRY_W'(MAX_RETRY - 1));
    assign value         = prev_q;

    // Capture stage plus window counters; counters clear outside the window.
    always_ff @(posedge sys_clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            freq_s  <= '0;
            prev_q  <= '0;
            timer_q <= '0;
            match_q <= '0;
            retry_q <= '0;
        end else begin
            freq_s <= freq_in;
            case (state)
                SETTLE: begin
                    timer_q <= timer_q + 1'b1;
                    if (settle_done_c) begin
                        prev_q <= freq_s;
                    end
                end
                SAMPLE: begin
                    prev_q <= freq_s;
                    if (is_match_c) begin
                        match_q <= match_q + 1'b1;
                    end else begin
                        match_q <= '0;
                        retry_q <= retry_q + 1'b1;
                    end
                end
                default: begin
                    timer_q <= '0;
                    match_q <= '0;
                    retry_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/freq_result_capture.sv
// Samples the 1 s-gate counter result once per gate period, qualifies it by
// stability, keeps min/max/block-average statistics and offers each accepted
// result over a valid/ready handshake.
// Ports:
//   sys_clk_50m, sys_rst_n : 50 MHz clock, async active-low reset
//   gate_1s                : counter gate, high while counting
//   freq_in                : counter result (async, quasi-static)
//   stats_clr              : one-cycle clear of statistics and sticky flags
//   res_if                 : result handshake (master side)
//   freq_min/freq_max      : extremes of accepted values since clear
//   freq_avg, avg_valid    : last block average and its update pulse
//   meas_cnt               : accepted results since clear (saturating)
//   dropped, cap_err       : sticky overrun / capture-error flags
module freq_result_capture
    import freq_meas_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned STABLE_SAMPLES = 3,
    parameter int unsigned MAX_RETRY      = 8,
    parameter int unsigned AVG_LOG2       = 3
) (
    input  logic                  sys_clk_50m,
    input  logic                  sys_rst_n,
    input  logic                  gate_1s,
    input  freq_t                 freq_in,
    input  logic                  stats_clr,
    freq_result_capture_if.master res_if,
    output freq_t                 freq_min,
    output freq_t                 freq_max,
    output freq_t                 freq_avg,
    output logic                  avg_valid,
    output logic [CNT_W-1:0]      meas_cnt,
    output logic                  dropped,
    output logic                  cap_err
);

    localparam int unsigned ACC_W = FREQ_W + AVG_LOG2;

    state_t              state_q;
    state_t              state_d;
    logic                gate_q;
    logic                gate_prev_q;
    logic                gate_fall_c;
    logic                settle_done_c;
    logic                stable_c;
    logic                err_c;
    logic                upd_c;
    freq_t               cap_val;
    logic                res_valid_q;
    freq_t               res_data_q;
    logic [ACC_W-1:0]    acc_q;
    logic [AVG_LOG2-1:0] blk_q;

    freq_t               min_base_c;
    freq_t               max_base_c;
    logic [CNT_W-1:0]    cnt_base_c;
    logic [ACC_W-1:0]    acc_base_c;
    logic [ACC_W-1:0]    acc_sum_c;
    logic [AVG_LOG2-1:0] blk_base_c;
    logic                drop_base_c;
    logic                err_base_c;

    assign res_if.res_valid = res_valid_q;
    assign res_if.res_data  = res_data_q;

    freq_stable_sampler #(
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .STABLE_SAMPLES (STABLE_SAMPLES),
        .MAX_RETRY      (MAX_RETRY)
    ) u_sampler (
        .sys_clk_50m   (sys_clk_50m),
        .sys_rst_n     (sys_rst_n),
        .state         (state_q),
        .freq_in       (freq_in),
        .settle_done_c (settle_done_c),
        .stable_c      (stable_c),
        .err_c         (err_c),
        .value         (cap_val)
    );

    // Gate edge detection on the registered gate.
    always_ff @(posedge sys_clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gate_q      <= 1'b0;
            gate_prev_q <= 1'b0;
        end else begin
            gate_q      <= gate_1s;
            gate_prev_q <= gate_q;
        end
    end

    assign gate_fall_c = gate_prev_q && !gate_q;
    assign upd_c       = (state_q == UPDATE);

    // State register.
    always_ff @(posedge sys_clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; gate edges outside IDLE are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gate_fall_c) state_d = SETTLE;
            SETTLE:  if (settle_done_c) state_d = SAMPLE;
            SAMPLE: begin
                if (stable_c) begin
                    state_d = UPDATE;
                end else if (err_c) begin
                    state_d = IDLE;
                end
            end
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Statistics as seen after a coincident clear, so an UPDATE in the
    // clear cycle becomes the first post-clear entry.
    always_comb begin
        min_base_c  = stats_clr ? MIN_RESET : freq_min;
        max_base_c  = stats_clr ? '0 : freq_max;
        cnt_base_c  = stats_clr ? '0 : meas_cnt;
        acc_base_c  = stats_clr ? '0 : acc_q;
        blk_base_c  = stats_clr ? '0 : blk_q;
        drop_base_c = stats_clr ? 1'b0 : dropped;
        err_base_c  = stats_clr ? 1'b0 : cap_err;
        acc_sum_c   = acc_base_c + ACC_W'(cap_val);
    end

    // Result holding register, statistics and sticky flags.
    always_ff @(posedge sys_clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            freq_min    <= MIN_RESET;
            freq_max    <= '0;
            freq_avg    <= '0;
            avg_valid   <= 1'b0;
            meas_cnt    <= '0;
            dropped     <= 1'b0;
            cap_err     <= 1'b0;
            acc_q       <= '0;
            blk_q       <= '0;
        end else begin
            avg_valid <= 1'b0;
            cap_err   <= err_base_c | err_c;
            dropped   <= drop_base_c | (upd_c && res_valid_q && !res_if.res_ready);

            // A load in the same cycle as an accept keeps valid high.
            if (upd_c && !(res_valid_q && !res_if.res_ready)) begin
                res_data_q  <= cap_val;
                res_valid_q <= 1'b1;
            end else if (res_valid_q && res_if.res_ready) begin
                res_valid_q <= 1'b0;
            end

            freq_min <= (upd_c && (cap_val < min_base_c)) ? cap_val : min_base_c;
            freq_max <= (upd_c && (cap_val > max_base_c)) ? cap_val : max_base_c;
            meas_cnt <= (upd_c && (cnt_base_c != '1)) ? cnt_base_c + 1'b1 : cnt_base_c;

            if (upd_c) begin
                if (&blk_base_c) begin
                    freq_avg  <= FREQ_W'(acc_sum_c >> AVG_LOG2);
                    avg_valid <= 1'b1;
                    acc_q     <= '0;
                    blk_q     <= '0;
                end else begin
                    acc_q <= acc_sum_c;
                    blk_q <= blk_base_c + 1'b1;
                end
            end else begin
                acc_q <= acc_base_c;
                blk_q <= blk_base_c;
            end
        end
    end

endmodule

// File: tb/tb_freq_result_capture.sv
// Self-checking bench for freq_result_capture: scoreboard of expected results
// plus a small reference model of the statistics.
module tb_freq_result_capture;
    import freq_meas_pkg::*;

    localparam int unsigned SETTLE = 1024;
    localparam int unsigned STABLE = 3;
    localparam int unsigned RETRY  = 8;
    localparam int unsigned AVG_L  = 3;
    localparam int unsigned LAT    = SETTLE + STABLE + 1;

    logic        sys_clk_50m = 1'b0;
    logic        sys_rst_n   = 1'b0;
    logic        gate_1s     = 1'b0;
    logic        stats_clr   = 1'b0;
    freq_t       freq_in     = '0;
    freq_t       freq_min;
    freq_t       freq_max;
    freq_t       freq_avg;
    logic        avg_valid;
    logic [31:0] meas_cnt;
    logic        dropped;
    logic        cap_err;

    freq_result_capture_if res_if();

    freq_result_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .STABLE_SAMPLES (STABLE),
        .MAX_RETRY      (RETRY),
        .AVG_LOG2       (AVG_L)
    ) dut (
        .sys_clk_50m (sys_clk_50m),
        .sys_rst_n   (sys_rst_n),
        .gate_1s     (gate_1s),
        .freq_in     (freq_in),
        .stats_clr   (stats_clr),
        .res_if      (res_if),
        .freq_min    (freq_min),
        .freq_max    (freq_max),
        .freq_avg    (freq_avg),
        .avg_valid   (avg_valid),
        .meas_cnt    (meas_cnt),
        .dropped     (dropped),
        .cap_err     (cap_err)
    );

    always #10 sys_clk_50m = ~sys_clk_50m;

    int n_checks = 0;
    int n_pass   = 0;
    int avg_pulses = 0;

    always @(negedge sys_clk_50m) if (avg_valid === 1'b1) avg_pulses++;

    // Scoreboard and reference model.
    freq_t       exp_q[$];
    freq_t       m_min, m_max, m_avg;
    logic [31:0] m_cnt;
    logic [66:0] m_acc;
    int          m_blk;

    task automatic model_clear();
        m_min = '1; m_max = '0; m_cnt = '0; m_acc = '0; m_blk = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_avg = '0;
        exp_q.delete();
    endtask

    task automatic model_accept(input freq_t v);
        if (v < m_min) m_min = v;
        if (v > m_max) m_max = v;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_acc = m_acc + 67'(v);
        m_blk++;
        if (m_blk == (1 << AVG_L)) begin
            m_avg = 64'(m_acc >> AVG_L);
            m_acc = '0;
            m_blk = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk_50m);
        #1;
    endtask

    task automatic drop_gate();
        gate_1s = 1'b1;
        tick(4);
        gate_1s = 1'b0;
    endtask

    task automatic pulse_clr();
        stats_clr = 1'b1;
        tick(1);
        stats_clr = 1'b0;
        model_clear();
    endtask

    task automatic wait_result(output bit ok, output int cyc);
        cyc = 0;
        while (res_if.res_valid !== 1'b1 && cyc < int'(LAT) + 100) begin
            tick(1);
            cyc++;
        end
        ok = (res_if.res_valid === 1'b1);
    endtask

    task automatic wait_state(input state_t s, output bit ok);
        int n;
        n = 0;
        while (dut.state_q !== s && n < int'(LAT) + 100) begin
            tick(1);
            n++;
        end
        ok = (dut.state_q === s);
    endtask

    task automatic pop_exp(output freq_t e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
    endtask

    task automatic test_reset();
        n_checks++; if (res_if.res_valid !== 1'b0) $display("FAIL reset_valid got %0h exp 0", res_if.res_valid); else n_pass++;
        n_checks++; if (res_if.res_data !== 64'd0) $display("FAIL reset_data got %0h exp 0", res_if.res_data); else n_pass++;
        n_checks++; if (freq_min !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL reset_min got %0h exp all-ones", freq_min); else n_pass++;
        n_checks++; if (freq_max !== 64'd0) $display("FAIL reset_max got %0h exp 0", freq_max); else n_pass++;
        n_checks++; if (freq_avg !== 64'd0) $display("FAIL reset_avg got %0h exp 0", freq_avg); else n_pass++;
        n_checks++; if (meas_cnt !== 32'd0) $display("FAIL reset_cnt got %0h exp 0", meas_cnt); else n_pass++;
        n_checks++; if ({avg_valid, dropped, cap_err} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {avg_valid, dropped, cap_err}); else n_pass++;
    endtask

    task automatic test_basic();
        bit ok; int cyc; freq_t e;
        res_if.res_ready = 1'b1;
        freq_in = 64'd50_000_000;
        exp_q.push_back(freq_in);
        model_accept(freq_in);
        drop_gate();
        wait_result(ok, cyc);
        n_checks++; if (!ok) $display("FAIL basic_timeout got no res_valid exp res_valid"); else n_pass++;
        n_checks++; if (cyc < int'(LAT) - 1 || cyc > int'(LAT) + 2) $display("FAIL basic_latency got %0d exp %0d..%0d", cyc, LAT - 1, LAT + 2); else n_pass++;
        pop_exp(e);
        n_checks++; if (res_if.res_data !== e) $display("FAIL basic_data got %0d exp %0d", res_if.res_data, e); else n_pass++;
        n_checks++; if (freq_min !== m_min || freq_max !== m_max) $display("FAIL basic_minmax got %0d/%0d exp %0d/%0d", freq_min, freq_max, m_min, m_max); else n_pass++;
        n_checks++; if (meas_cnt !== m_cnt) $display("FAIL basic_cnt got %0d exp %0d", meas_cnt, m_cnt); else n_pass++;
        tick(1);
        n_checks++; if (res_if.res_valid !== 1'b0) $display("FAIL basic_accept got valid %b exp 0", res_if.res_valid); else n_pass++;
    endtask

    task automatic test_gate_ignored();
        bit ok; int cyc; freq_t e;
        freq_in = 64'd60_000;
        exp_q.push_back(freq_in);
        model_accept(freq_in);
        drop_gate();
        tick(300);
        gate_1s = 1'b1;
        tick(3);
        gate_1s = 1'b0;
        wait_result(ok, cyc);
        cyc = cyc + 303;
        n_checks++; if (!ok || cyc > int'(LAT) + 2) $display("FAIL ignore_latency got %0d ok=%0d exp <=%0d", cyc, ok, LAT + 2); else n_pass++;
        pop_exp(e);
        n_checks++; if (res_if.res_data !== e) $display("FAIL ignore_data got %0d exp %0d", res_if.res_data, e); else n_pass++;
        tick(LAT + 10);
        n_checks++; if (meas_cnt !== m_cnt) $display("FAIL ignore_single got cnt %0d exp %0d", meas_cnt, m_cnt); else n_pass++;
    endtask

    task automatic test_unstable();
        bit ok; int cyc; bit saw_valid; freq_t e;
        saw_valid = 1'b0;
        freq_in = 64'h5555_5555_5555_5555;
        drop_gate();
        for (int i = 0; i < int'(LAT) + 40; i++) begin
            freq_in = ~freq_in;
            tick(1);
            if (res_if.res_valid === 1'b1) saw_valid = 1'b1;
        end
        n_checks++; if (saw_valid) $display("FAIL unstable_valid got res_valid exp none"); else n_pass++;
        n_checks++; if (cap_err !== 1'b1) $display("FAIL unstable_err got %b exp 1", cap_err); else n_pass++;
        n_checks++; if (meas_cnt !== m_cnt) $display("FAIL unstable_cnt got %0d exp %0d", meas_cnt, m_cnt); else n_pass++;
        freq_in = 64'd12345;
        exp_q.push_back(freq_in);
        model_accept(freq_in);
        drop_gate();
        wait_result(ok, cyc);
        pop_exp(e);
        n_checks++; if (!ok || res_if.res_data !== e) $display("FAIL recover_data got %0d ok=%0d exp %0d", res_if.res_data, ok, e); else n_pass++;
        n_checks++; if (cap_err !== 1'b1) $display("FAIL recover_err_sticky got %b exp 1", cap_err); else n_pass++;
        tick(2);
    endtask

    task automatic test_clear();
        pulse_clr();
        n_checks++; if (cap_err !== 1'b0) $display("FAIL clear_err got %b exp 0", cap_err); else n_pass++;
        n_checks++; if (freq_min !== m_min || freq_max !== m_max || meas_cnt !== m_cnt) $display("FAIL clear_stats got %0h/%0h/%0d exp %0h/%0h/%0d", freq_min, freq_max, meas_cnt, m_min, m_max, m_cnt); else n_pass++;
        n_checks++; if (res_if.res_data !== 64'd12345 || freq_avg !== m_avg) $display("FAIL clear_keep got data %0d avg %0d exp 12345 %0d", res_if.res_data, freq_avg, m_avg); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok; int cyc; freq_t e;
        pulse_clr();
        res_if.res_ready = 1'b0;
        freq_in = 64'd1000;
        exp_q.push_back(freq_in);
        model_accept(freq_in);
        drop_gate();
        wait_result(ok, cyc);
        pop_exp(e);
        n_checks++; if (!ok || res_if.res_data !== e) $display("FAIL bp_first got %0d ok=%0d exp %0d", res_if.res_data, ok, e); else n_pass++;
        freq_in = 64'd2000;
        model_accept(freq_in);
        drop_gate();
        tick(LAT + 10);
        n_checks++; if (res_if.res_valid !== 1'b1 || res_if.res_data !== 64'd1000) $display("FAIL bp_hold got v=%b d=%0d exp v=1 d=1000", res_if.res_valid, res_if.res_data); else n_pass++;
        n_checks++; if (dropped !== 1'b1) $display("FAIL bp_dropped got %b exp 1", dropped); else n_pass++;
        n_checks++; if (meas_cnt !== m_cnt || freq_max !== m_max) $display("FAIL bp_stats got cnt %0d max %0d exp %0d %0d", meas_cnt, freq_max, m_cnt, m_max); else n_pass++;
        res_if.res_ready = 1'b1;
        tick(1);
        n_checks++; if (res_if.res_valid !== 1'b0) $display("FAIL bp_release got %b exp 0", res_if.res_valid); else n_pass++;
    endtask

    task automatic test_average();
        bit ok; int cyc; int p0; freq_t e;
        pulse_clr();
        n_checks++; if (dropped !== 1'b0) $display("FAIL avg_clr_dropped got %b exp 0", dropped); else n_pass++;
        p0 = avg_pulses;
        for (int k = 1; k <= 9; k++) begin
            freq_in = 64'(k * 100);
            exp_q.push_back(freq_in);
            model_accept(freq_in);
            drop_gate();
            wait_result(ok, cyc);
            pop_exp(e);
            n_checks++; if (!ok || res_if.res_data !== e) $display("FAIL avg_data%0d got %0d ok=%0d exp %0d", k, res_if.res_data, ok, e); else n_pass++;
            tick(2);
            if (k == 8) begin
                n_checks++; if (avg_pulses - p0 != 1) $display("FAIL avg_pulse got %0d exp 1", avg_pulses - p0); else n_pass++;
                n_checks++; if (freq_avg !== m_avg) $display("FAIL avg_value got %0d exp %0d", freq_avg, m_avg); else n_pass++;
            end
        end
        n_checks++; if (avg_pulses - p0 != 1 || freq_avg !== 64'd450) $display("FAIL avg_restart got pulses %0d avg %0d exp 1 450", avg_pulses - p0, freq_avg); else n_pass++;
        n_checks++; if (meas_cnt !== m_cnt) $display("FAIL avg_cnt got %0d exp %0d", meas_cnt, m_cnt); else n_pass++;
    endtask

    task automatic test_clear_collision();
        bit ok; int cyc; freq_t e;
        freq_in = 64'd777;
        drop_gate();
        wait_state(UPDATE, ok);
        n_checks++; if (!ok) $display("FAIL coll_timeout got no UPDATE exp UPDATE"); else n_pass++;
        stats_clr = 1'b1;
        model_clear();
        model_accept(freq_in);
        exp_q.push_back(freq_in);
        tick(1);
        stats_clr = 1'b0;
        wait_result(ok, cyc);
        pop_exp(e);
        n_checks++; if (!ok || res_if.res_data !== e) $display("FAIL coll_data got %0d exp %0d", res_if.res_data, e); else n_pass++;
        n_checks++; if (freq_min !== m_min || freq_max !== m_max) $display("FAIL coll_minmax got %0d/%0d exp %0d/%0d", freq_min, freq_max, m_min, m_max); else n_pass++;
        n_checks++; if (meas_cnt !== m_cnt || dropped !== 1'b0) $display("FAIL coll_cnt got %0d drop %b exp %0d 0", meas_cnt, dropped, m_cnt); else n_pass++;
        tick(2);
    endtask

    task automatic test_reset_mid();
        bit ok; int cyc; freq_t e;
        freq_in = 64'd4242;
        drop_gate();
        wait_state(SAMPLE, ok);
        #3 sys_rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if (!ok || res_if.res_valid !== 1'b0 || res_if.res_data !== 64'd0) $display("FAIL rstmid_res got v=%b d=%0d exp 0 0", res_if.res_valid, res_if.res_data); else n_pass++;
        n_checks++; if (freq_min !== m_min || freq_max !== m_max || freq_avg !== m_avg || meas_cnt !== m_cnt) $display("FAIL rstmid_stats got %0h/%0h/%0h/%0h", freq_min, freq_max, freq_avg, meas_cnt); else n_pass++;
        tick(2);
        sys_rst_n = 1'b1;
        tick(2);
        exp_q.push_back(freq_in);
        model_accept(freq_in);
        drop_gate();
        wait_result(ok, cyc);
        pop_exp(e);
        n_checks++; if (!ok || res_if.res_data !== e) $display("FAIL rstmid_capture got %0d ok=%0d exp %0d", res_if.res_data, ok, e); else n_pass++;
        n_checks++; if (meas_cnt !== m_cnt || freq_min !== m_min || freq_max !== m_max) $display("FAIL rstmid_after got %0d %0d %0d exp %0d %0d %0d", meas_cnt, freq_min, freq_max, m_cnt, m_min, m_max); else n_pass++;
    endtask

    initial begin
        #(64'd3_000_000);
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res_if.res_ready = 1'b0;
        model_reset();
        tick(3);
        sys_rst_n = 1'b1;
        tick(2);
        test_reset();
        test_basic();
        test_gate_ignored();
        test_unstable();
        test_clear();
        test_backpressure();
        test_average();
        test_clear_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
